rgb_ycbcr: RTL and testbench
============================

RGB_YCBCR -- requirements
Module: rgb_ycbcr

Interface
REQ-001 The block SHALL have no parameters; all widths and coefficients are fixed.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-004 in_valid  input  1  in_data and in_sop are valid this cycle.
REQ-005 in_sop  input  1  start of pixel; qualifies the current byte as R.
REQ-006 in_data  input  8  unsigned colour byte, in the order R, G, B.
REQ-007 Y  output  16  unsigned luma, 8.8 fixed point.
REQ-008 Cb  output  16  unsigned blue-difference chroma, 8.8 fixed point, offset 128.0.
REQ-009 Cr  output  16  unsigned red-difference chroma, 8.8 fixed point, offset 128.0.
REQ-010 out_valid  output  1  one-cycle pulse marking a new Y/Cb/Cr triple.

Function
REQ-011 A byte SHALL be accepted only on an edge where in_valid=1; in_data is ignored when in_valid=0.
REQ-012 A 2-bit phase counter SHALL select the byte role: 0=R, 1=G, 2=B.
- The counter advances on each accepted byte and wraps from 2 to 0.
- The counter holds while in_valid=0.
REQ-013 An accepted byte with in_sop=1 SHALL be taken as R and SHALL set the phase to 1, regardless of the current phase.
- Any partial triple in progress is discarded.
REQ-014 in_sop SHALL be ignored when in_valid=0.
REQ-015 Coefficients SHALL be Q2.14 constants:
- Y: 4899, 9617, 1868
- Cb: -2765, -5427, 8192
- Cr: 8192, -6860, -1332
REQ-016 Each raw sum SHALL be formed as sum(coef*byte), plus 128*16384 for Cb and Cr.
- Width: at least 24-bit signed.
REQ-017 Each output SHALL equal (raw + 32) >> 6, saturated to 0..65535.
- Result tolerance: |out - exact*256| < 128.
REQ-018 Pipeline stages:
- Stage 1, on the edge that accepts B: register the nine products, or their partial sums.
- Stage 2, on the following edge: register the rounded outputs and assert out_valid.
REQ-019 Latency: if B is accepted on edge N, the new Y/Cb/Cr and out_valid=1 SHALL be visible after edge N+1.
- out_valid SHALL deassert after edge N+2 unless another triple also completes.
REQ-020 Y, Cb and Cr SHALL hold their last values between out_valid pulses.
REQ-021 Back-to-back triples with in_valid held at 1 SHALL produce one out_valid pulse every 3 cycles, with no stall and no dropped pixel.
REQ-022 Stage 1 and stage 2 SHALL operate independently of input gaps: a triple completed before a gap still emits on schedule.

Reset
REQ-023 While reset=0 at an edge, the following SHALL clear:
- phase = 0
- both pipeline stages
- out_valid = 0
- Y = 0x0000, Cb = 0x0000, Cr = 0x0000
REQ-024 Reset asserted mid-triple SHALL discard the partial triple and any result in flight; no out_valid SHALL follow.
REQ-025 The first byte accepted after reset deasserts SHALL be treated as R.

Verification
REQ-026 R,G,B = 0,0,0 -> Y=0x0000, Cb=0x8000, Cr=0x8000, out_valid pulse one cycle after B is accepted.
REQ-027 R,G,B = 255,255,255 -> Y=0xFF00, Cb=0x8000, Cr=0x8000.
REQ-028 R,G,B = 255,0,0 -> Y=0x4C3F, Cb=0x54F7, Cr=0xFF80.
REQ-029 Handshake and throughput scenario:
- 20 random triples with random in_valid gaps -> each output within 127 LSB of a real-valued model.
- Exactly one out_valid per triple.
- Continuous streaming gives a pulse every 3 cycles.
REQ-030 Reset mid-triple: send R=255, G=0, pulse reset low one cycle, then send 0,0,0 -> one out_valid only, with Y=0x0000, Cb=0x8000, Cr=0x8000.
REQ-031 Resync: send 10,20 then 255(in_sop=1),0,0 -> one out_valid with Y=0x4C3F, Cb=0x54F7, Cr=0xFF80.

Source files
------------

// File: rtl/rgb_ycbcr.sv
// RGB to YCbCr converter. Bytes arrive as R, G, B; each completed triple
// goes through two registered stages (weighted sums, then round/saturate)
// and is announced by a one-cycle out_valid pulse.
module rgb_ycbcr (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic [7:0]  in_data,
  output logic [15:0] Y,
  output logic [15:0] Cb,
  output logic [15:0] Cr,
  output logic        out_valid
);

  // Q2.14 coefficients.
  localparam logic signed [24:0] YR  = 25'sd4899;
  localparam logic signed [24:0] YG  = 25'sd9617;
  localparam logic signed [24:0] YB  = 25'sd1868;
  localparam logic signed [24:0] CbR = -25'sd2765;
  localparam logic signed [24:0] CbG = -25'sd5427;
  localparam logic signed [24:0] CbB = 25'sd8192;
  localparam logic signed [24:0] CrR = 25'sd8192;
  localparam logic signed [24:0] CrG = -25'sd6860;
  localparam logic signed [24:0] CrB = -25'sd1332;
  // 128.0 in Q2.14 scaling.
  localparam logic signed [24:0] ChromaOfs = 25'sd2097152;

  logic [1:0]         phase_q, phase_d;
  logic [7:0]         r_q, r_d;
  logic [7:0]         g_q, g_d;
  logic               s1_valid_q, s1_valid_d;
  logic signed [24:0] sum_y_q, sum_y_d;
  logic signed [24:0] sum_cb_q, sum_cb_d;
  logic signed [24:0] sum_cr_q, sum_cr_d;
  logic [15:0]        y_q, y_d;
  logic [15:0]        cb_q, cb_d;
  logic [15:0]        cr_q, cr_d;
  logic               out_valid_q, out_valid_d;

  logic signed [24:0] r_s, g_s, b_s;

  // (raw + 32) >> 6, clamped to the 16-bit unsigned output range.
  function automatic logic [15:0] round_sat(input logic signed [24:0] raw);
    logic signed [24:0] t;
    t = (raw + 25'sd32) >>> 6;
    if (t < 25'sd0) begin
      round_sat = 16'h0000;
    end else if (t > 25'sd65535) begin
      round_sat = 16'hFFFF;
    end else begin
      round_sat = t[15:0];
    end
  endfunction

  assign r_s = $signed({17'd0, r_q});
  assign g_s = $signed({17'd0, g_q});
  assign b_s = $signed({17'd0, in_data});

  // Byte capture, phase tracking and stage-1 sums on the edge that accepts B.
  always_comb begin
    phase_d    = phase_q;
    r_d        = r_q;
    g_d        = g_q;
    s1_valid_d = 1'b0;
    sum_y_d    = sum_y_q;
    sum_cb_d   = sum_cb_q;
    sum_cr_d   = sum_cr_q;
    if (in_valid) begin
      if (in_sop) begin
        // Start of pixel always resynchronises to R, dropping any partial triple.
        r_d     = in_data;
        phase_d = 2'd1;
      end else begin
        unique case (phase_q)
          2'd0: begin
            r_d     = in_data;
            phase_d = 2'd1;
          end
          2'd1: begin
            g_d     = in_data;
            phase_d = 2'd2;
          end
          2'd2: begin
            phase_d    = 2'd0;
            s1_valid_d = 1'b1;
            sum_y_d    = YR * r_s + YG * g_s + YB * b_s;
            sum_cb_d   = CbR * r_s + CbG * g_s + CbB * b_s + ChromaOfs;
            sum_cr_d   = CrR * r_s + CrG * g_s + CrB * b_s + ChromaOfs;
          end
          default: begin
            phase_d = 2'd0;
          end
        endcase
      end
    end
  end

  // Stage 2: round and saturate; outputs hold between pulses.
  always_comb begin
    out_valid_d = s1_valid_q;
    y_d         = y_q;
    cb_d        = cb_q;
    cr_d        = cr_q;
    if (s1_valid_q) begin
      y_d  = round_sat(sum_y_q);
      cb_d = round_sat(sum_cb_q);
      cr_d = round_sat(sum_cr_q);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q     <= 2'd0;
      r_q         <= 8'd0;
      g_q         <= 8'd0;
      s1_valid_q  <= 1'b0;
      sum_y_q     <= '0;
      sum_cb_q    <= '0;
      sum_cr_q    <= '0;
      y_q         <= 16'h0000;
      cb_q        <= 16'h0000;
      cr_q        <= 16'h0000;
      out_valid_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      r_q         <= r_d;
      g_q         <= g_d;
      s1_valid_q  <= s1_valid_d;
      sum_y_q     <= sum_y_d;
      sum_cb_q    <= sum_cb_d;
      sum_cr_q    <= sum_cr_d;
      y_q         <= y_d;
      cb_q        <= cb_d;
      cr_q        <= cr_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Y         = y_q;
  assign Cb        = cb_q;
  assign Cr        = cr_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rgb_ycbcr.sv
// Self-checking bench for rgb_ycbcr: directed colour vectors, random triples
// against a real-valued BT.601 model, streaming rate, reset and resync cases.
module tb_rgb_ycbcr;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_sop;
  logic [7:0]  in_data;
  logic [15:0] Y, Cb, Cr;
  logic        out_valid;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [47:0] obs_q[$];
  int          obs_cyc_q[$];
  real         exp_y_q[$], exp_cb_q[$], exp_cr_q[$];

  rgb_ycbcr dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_data   (in_data),
    .Y         (Y),
    .Cb        (Cb),
    .Cr        (Cr),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Cycle counter and output collector, sampled mid-cycle.
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (out_valid) begin
      obs_q.push_back({Y, Cb, Cr});
      obs_cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input real exp);
    real d;
    d = real'(obs) - exp;
    vectors++;
    assert (d < 128.0 && d > -128.0) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0f (+/-127)", tag, obs, exp);
    end
  endtask

  // Each call applies one edge; inputs change 1 time unit after the edge.
  task automatic send(input logic [7:0] d, input logic sop);
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = sop;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_data  = $urandom_range(0, 255);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_sop   = $urandom_range(0, 1);
      in_data  = $urandom_range(0, 255);
      @(posedge clk);
      #1;
    end
    in_sop = 1'b0;
  endtask

  // Reference: exact BT.601 transform, scaled by 256 into output LSBs.
  task automatic model(input int r, input int g, input int b);
    exp_y_q.push_back(256.0 * (0.299 * r + 0.587 * g + 0.114 * b));
    exp_cb_q.push_back(256.0 * (-0.168736 * r - 0.331264 * g + 0.5 * b + 128.0));
    exp_cr_q.push_back(256.0 * (0.5 * r - 0.418688 * g - 0.081312 * b + 128.0));
  endtask

  task automatic chk_one(input string tag, input logic [15:0] ey, input logic [15:0] ecb,
                         input logic [15:0] ecr);
    logic [47:0] o;
    chk({tag, "_count"}, obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      o = obs_q[0];
      chk({tag, "_Y"}, o[47:32], ey);
      chk({tag, "_Cb"}, o[31:16], ecb);
      chk({tag, "_Cr"}, o[15:0], ecr);
    end
  endtask

  initial begin
    logic [7:0] r, g, b;
    logic [47:0] o;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_data  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_Y", Y, 16'h0000);
    chk("reset_Cb", Cb, 16'h0000);
    chk("reset_Cr", Cr, 16'h0000);
    chk("reset_valid", out_valid, 1'b0);
    reset = 1'b1;
    idle(1);

    // Black, with exact latency checks around the B edge.
    send(8'd0, 1'b0); send(8'd0, 1'b0); send(8'd0, 1'b0);
    chk("black_no_early_valid", out_valid, 1'b0);
    idle(1);
    chk("black_valid", out_valid, 1'b1);
    chk("black_Y", Y, 16'h0000);
    chk("black_Cb", Cb, 16'h8000);
    chk("black_Cr", Cr, 16'h8000);
    idle(1);
    chk("black_valid_drop", out_valid, 1'b0);
    chk("black_Cb_hold", Cb, 16'h8000);

    send(8'd255, 1'b0); send(8'd255, 1'b0); send(8'd255, 1'b0);
    idle(1);
    chk("white_Y", Y, 16'hFF00);
    chk("white_Cb", Cb, 16'h8000);
    chk("white_Cr", Cr, 16'h8000);

    send(8'd255, 1'b0); send(8'd0, 1'b0); send(8'd0, 1'b0);
    idle(1);
    chk("red_Y", Y, 16'h4C3F);
    chk("red_Cb", Cb, 16'h54F7);
    chk("red_Cr", Cr, 16'hFF80);
    idle(3);
    chk("red_hold_Y", Y, 16'h4C3F);

    // Random triples with random gaps.
    obs_q.delete();
    obs_cyc_q.delete();
    for (int t = 0; t < 20; t++) begin
      r = $urandom_range(0, 255);
      g = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      model(r, g, b);
      idle($urandom_range(0, 2)); send(r, t[0]);
      idle($urandom_range(0, 2)); send(g, 1'b0);
      idle($urandom_range(0, 2)); send(b, 1'b0);
    end
    idle(4);
    chk("rand_count", obs_q.size(), 20);
    for (int i = 0; i < 20 && i < obs_q.size(); i++) begin
      o = obs_q[i];
      chk_tol($sformatf("rand%0d_Y", i), int'(o[47:32]), exp_y_q[i]);
      chk_tol($sformatf("rand%0d_Cb", i), int'(o[31:16]), exp_cb_q[i]);
      chk_tol($sformatf("rand%0d_Cr", i), int'(o[15:0]), exp_cr_q[i]);
    end

    // Continuous streaming: one pulse every 3 cycles.
    obs_q.delete();
    obs_cyc_q.delete();
    for (int t = 0; t < 6; t++) begin
      send($urandom_range(0, 255), 1'b0);
      send($urandom_range(0, 255), 1'b0);
      send($urandom_range(0, 255), 1'b0);
    end
    idle(4);
    chk("stream_count", obs_q.size(), 6);
    for (int i = 1; i < obs_cyc_q.size(); i++) begin
      chk($sformatf("stream_gap%0d", i), obs_cyc_q[i] - obs_cyc_q[i-1], 3);
    end

    // Reset mid-triple; first byte after reset is R.
    obs_q.delete();
    send(8'd255, 1'b0); send(8'd0, 1'b0);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    send(8'd0, 1'b0); send(8'd0, 1'b0); send(8'd0, 1'b0);
    idle(4);
    chk_one("rst_mid", 16'h0000, 16'h8000, 16'h8000);

    // Reset with a result in flight: no pulse, outputs cleared.
    obs_q.delete();
    send(8'd255, 1'b0); send(8'd0, 1'b0); send(8'd0, 1'b0);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    idle(4);
    chk("rst_flight_count", obs_q.size(), 0);
    chk("rst_flight_Cb", Cb, 16'h0000);

    // Resync on in_sop mid-triple.
    obs_q.delete();
    send(8'd10, 1'b0); send(8'd20, 1'b0);
    send(8'd255, 1'b1); send(8'd0, 1'b0); send(8'd0, 1'b0);
    idle(4);
    chk_one("resync", 16'h4C3F, 16'h54F7, 16'hFF80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
